// File: rtl/uart_pkg.sv
// Shared constants, FSM state encodings and parity helper for the buffered UART.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    localparam int BIT_TICKS = 16;
    localparam int MID_TICKS = 8;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    function automatic logic parity_of(input logic [7:0] d, input int mode);
        return (mode == PARITY_ODD)  ? ~^d :
               (mode == PARITY_EVEN) ?  ^d : 1'b0;
    endfunction

endpackage

// File: rtl/uart_buffered_if.sv
// Streaming byte ports between the io decoder (master) and the UART (slave).
interface uart_buffered_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (output tx_data, tx_valid, rx_ready,
                    input  tx_ready, rx_data, rx_valid);
    modport slave  (input  tx_data, tx_valid, rx_ready,
                    output tx_ready, rx_data, rx_valid);
endinterface

// File: rtl/sync_fifo.sv
// First-word fall-through synchronous FIFO; head reads as 0 while empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    // a push into a full FIFO is accepted when the head leaves in the same cycle
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            level <= level + LW'(push_ok) - LW'(pop_ok);
        end
    end
endmodule

// File: rtl/uart_buffered.sv
// Buffered UART: runtime 16x baud divisor, optional parity, TX/RX FIFOs, sticky line errors.
// TX: IDLE wait | START start bit | DATA 8 bits | PARITY opt | STOP. RX adds BREAK: wait for line high.
module uart_buffered
    import uart_pkg::*;
#(
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16,
    parameter int DIV_W    = 16,
    parameter int PARITY   = 0
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [DIV_W-1:0]           baud_div,
    uart_buffered_if.slave             bus,
    input  logic                       err_clr,
    output logic                       overrun,
    output logic                       frame_err,
    output logic                       parity_err,
    output logic [$clog2(TX_DEPTH):0]  tx_level,
    output logic [$clog2(RX_DEPTH):0]  rx_level,
    output logic                       tx_busy,
    output logic                       txd,
    input  logic                       rxd
);
    localparam logic [3:0] LAST_TICK = 4'(BIT_TICKS - 1);
    localparam logic [3:0] MID_LAST  = 4'(MID_TICKS - 1);
    localparam bit         HAS_PAR   = (PARITY != PARITY_NONE);

    logic [DIV_W-1:0] tick_cnt;
    logic             tick;

    // >= rather than == so a smaller new divisor never waits for a counter wrap
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tick_cnt <= '0;
            tick     <= 1'b0;
        end else if (tick_cnt >= baud_div) begin
            tick_cnt <= '0;
            tick     <= 1'b1;
        end else begin
            tick_cnt <= tick_cnt + DIV_W'(1);
            tick     <= 1'b0;
        end
    end

    logic       tx_full, tx_empty, tx_push, tx_pop;
    logic [7:0] tx_head;
    logic       rx_full, rx_empty, rx_push, rx_pop;
    logic [7:0] rx_head;

    assign tx_push      = bus.tx_valid && !tx_full;
    assign bus.tx_ready = !tx_full;
    assign rx_pop       = bus.rx_ready && !rx_empty;
    assign bus.rx_valid = !rx_empty;
    assign bus.rx_data  = rx_head;

    tx_state_t  tx_state;
    logic [3:0] tx_tcnt;
    logic [2:0] tx_bit;
    logic [7:0] tx_shift;
    logic       tx_par;

    // loading at the end of STOP chains frames with no idle gap
    assign tx_pop = tick && !tx_empty &&
                    (tx_state == TX_IDLE || (tx_state == TX_STOP && tx_tcnt == LAST_TICK));

    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk(clk), .resetn(resetn),
        .push(tx_push), .wr_data(bus.tx_data),
        .pop(tx_pop), .rd_data(tx_head),
        .full(tx_full), .empty(tx_empty), .level(tx_level)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tx_state <= TX_IDLE;
            tx_tcnt  <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
            tx_busy  <= 1'b0;
            txd      <= 1'b1;
        end else if (tx_pop) begin
            tx_state <= TX_START;
            tx_tcnt  <= '0;
            tx_bit   <= '0;
            tx_shift <= tx_head;
            tx_par   <= parity_of(tx_head, PARITY);
            tx_busy  <= 1'b1;
            txd      <= 1'b0;
        end else if (tick && tx_state != TX_IDLE) begin
            tx_tcnt <= tx_tcnt + 4'd1;
            if (tx_tcnt == LAST_TICK) begin
                case (tx_state)
                    TX_START: begin
                        tx_state <= TX_DATA;
                        txd      <= tx_shift[0];
                    end
                    TX_DATA: begin
                        if (tx_bit == 3'd7) begin
                            tx_state <= HAS_PAR ? TX_PARITY : TX_STOP;
                            txd      <= HAS_PAR ? tx_par : 1'b1;
                        end else begin
                            tx_shift <= tx_shift >> 1;
                            txd      <= tx_shift[1];
                            tx_bit   <= tx_bit + 3'd1;
                        end
                    end
                    TX_PARITY: begin
                        tx_state <= TX_STOP;
                        txd      <= 1'b1;
                    end
                    TX_STOP: begin
                        tx_state <= TX_IDLE;
                        tx_busy  <= 1'b0;
                    end
                    default: tx_state <= TX_IDLE;
                endcase
            end
        end
    end

    logic       rx_s1, rx_s2;
    rx_state_t  rx_state;
    logic [3:0] rx_tcnt;
    logic [2:0] rx_bit;
    logic [7:0] rx_shift;
    logic       rx_par;
    logic       frame_set, par_set, ovr_set;
    logic       par_ok;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
        end else begin
            rx_s1 <= rxd;
            rx_s2 <= rx_s1;
        end
    end

    assign par_ok = !HAS_PAR || (rx_par == parity_of(rx_shift, PARITY));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_state  <= RX_IDLE;
            rx_tcnt   <= '0;
            rx_bit    <= '0;
            rx_shift  <= '0;
            rx_par    <= 1'b0;
            rx_push   <= 1'b0;
            frame_set <= 1'b0;
            par_set   <= 1'b0;
        end else begin
            rx_push   <= 1'b0;
            frame_set <= 1'b0;
            par_set   <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (!rx_s2) begin
                        rx_state <= RX_START;
                        rx_tcnt  <= '0;
                    end
                end
                RX_START: begin
                    if (tick) begin
                        rx_tcnt <= rx_tcnt + 4'd1;
                        if (rx_tcnt == MID_LAST) begin
                            rx_tcnt  <= '0;
                            rx_bit   <= '0;
                            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
                        end
                    end
                end
                RX_DATA: begin
                    if (tick) begin
                        rx_tcnt <= rx_tcnt + 4'd1;
                        if (rx_tcnt == LAST_TICK) begin
                            rx_shift <= {rx_s2, rx_shift[7:1]};
                            rx_bit   <= rx_bit + 3'd1;
                            if (rx_bit == 3'd7) rx_state <= HAS_PAR ? RX_PARITY : RX_STOP;
                        end
                    end
                end
                RX_PARITY: begin
                    if (tick) begin
                        rx_tcnt <= rx_tcnt + 4'd1;
                        if (rx_tcnt == LAST_TICK) begin
                            rx_par   <= rx_s2;
                            rx_state <= RX_STOP;
                        end
                    end
                end
                RX_STOP: begin
                    if (tick) begin
                        rx_tcnt <= rx_tcnt + 4'd1;
                        if (rx_tcnt == LAST_TICK) begin
                            if (!rx_s2) begin
                                frame_set <= 1'b1;
                                rx_state  <= RX_BREAK;
                            end else begin
                                rx_state <= RX_IDLE;
                                if (par_ok) rx_push <= 1'b1;
                                else        par_set <= 1'b1;
                            end
                        end
                    end
                end
                RX_BREAK: begin
                    if (rx_s2) rx_state <= RX_IDLE;
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk(clk), .resetn(resetn),
        .push(rx_push), .wr_data(rx_shift),
        .pop(rx_pop), .rd_data(rx_head),
        .full(rx_full), .empty(rx_empty), .level(rx_level)
    );

    assign ovr_set = rx_push && rx_full && !rx_pop;

    // set wins over a simultaneous clear
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overrun    <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (ovr_set)        overrun <= 1'b1;
            else if (err_clr)   overrun <= 1'b0;
            if (frame_set)      frame_err <= 1'b1;
            else if (err_clr)   frame_err <= 1'b0;
            if (par_set)        parity_err <= 1'b1;
            else if (err_clr)   parity_err <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_buffered.sv
// Directed bench for uart_buffered: reset, TX framing, loopback, overrun, frame/parity errors, glitch reject.
`timescale 1ns/1ps
module tb_uart_buffered;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic [15:0] baud_div;
    logic        err_clr;
    logic        loop, sel1, rxd_drv;

    uart_buffered_if bus0();
    uart_buffered_if bus1();

    logic       ovr0, fe0, pe0, busy0, txd0, rxd0;
    logic [4:0] txl0, rxl0;
    logic       ovr1, fe1, pe1, busy1, txd1, rxd1;
    logic [4:0] txl1, rxl1;

    assign rxd0 = loop ? txd0 : (sel1 ? 1'b1 : rxd_drv);
    assign rxd1 = sel1 ? rxd_drv : 1'b1;

    uart_buffered #(.TX_DEPTH(16), .RX_DEPTH(16), .DIV_W(16), .PARITY(0)) dut0 (
        .clk(clk), .resetn(resetn), .baud_div(baud_div), .bus(bus0),
        .err_clr(err_clr), .overrun(ovr0), .frame_err(fe0), .parity_err(pe0),
        .tx_level(txl0), .rx_level(rxl0), .tx_busy(busy0), .txd(txd0), .rxd(rxd0)
    );

    uart_buffered #(.TX_DEPTH(16), .RX_DEPTH(16), .DIV_W(16), .PARITY(1)) dut1 (
        .clk(clk), .resetn(resetn), .baud_div(baud_div), .bus(bus1),
        .err_clr(err_clr), .overrun(ovr1), .frame_err(fe1), .parity_err(pe1),
        .tx_level(txl1), .rx_level(rxl1), .tx_busy(busy1), .txd(txd1), .rxd(rxd1)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Push count bytes base, base+1, ... with tx_valid held; report stall statistics.
    task automatic push_run(input int base, input int count, output int pushed,
                            output int stall_full, output int stall_bad, output int maxl);
        logic rdy;
        int   t;
        pushed = 0; stall_full = 0; stall_bad = 0; maxl = 0; t = 0;
        bus0.tx_valid = 1'b1;
        while (pushed < count && t < 20000) begin
            bus0.tx_data = 8'(base + pushed);
            rdy = bus0.tx_ready;
            if (int'(txl0) > maxl) maxl = int'(txl0);
            if (!rdy) begin
                if (txl0 == 5'd16) stall_full++;
                else               stall_bad++;
            end
            cyc(1);
            t++;
            if (rdy) pushed++;
        end
        bus0.tx_valid = 1'b0;
    endtask

    task automatic pop0(input string tag, input logic [7:0] exp);
        int t;
        t = 0;
        while (!bus0.rx_valid && t < 2000) begin
            cyc(1);
            t++;
        end
        chk({tag, "_valid"}, 32'(bus0.rx_valid), 32'd1);
        chk(tag, 32'(bus0.rx_data), 32'(exp));
        bus0.rx_ready = 1'b1;
        cyc(1);
        bus0.rx_ready = 1'b0;
    endtask

    // One frame on rxd_drv at 64 clk per bit; the line is left at the stop level.
    task automatic send_frame(input logic [7:0] d, input bit has_par, input logic pbit, input logic stop);
        rxd_drv = 1'b0;
        cyc(64);
        for (int b = 0; b < 8; b++) begin
            rxd_drv = d[b];
            cyc(64);
        end
        if (has_par) begin
            rxd_drv = pbit;
            cyc(64);
        end
        rxd_drv = stop;
        cyc(64);
    endtask

    int         t, n, idx, edge_err;
    int         pushed, stall_full, stall_bad, maxl;
    logic [9:0] fbits;

    initial begin
        resetn = 1'b0; baud_div = 16'd3; err_clr = 1'b0;
        loop = 1'b0; sel1 = 1'b0; rxd_drv = 1'b1;
        bus0.tx_data = '0; bus0.tx_valid = 1'b0; bus0.rx_ready = 1'b0;
        bus1.tx_data = '0; bus1.tx_valid = 1'b0; bus1.rx_ready = 1'b0;
        cyc(3);

        chk("rst_txd",      32'(txd0), 32'd1);
        chk("rst_tx_ready", 32'(bus0.tx_ready), 32'd1);
        chk("rst_rx_valid", 32'(bus0.rx_valid), 32'd0);
        chk("rst_rx_data",  32'(bus0.rx_data), 32'd0);
        chk("rst_levels",   32'({txl0, rxl0}), 32'd0);
        chk("rst_flags",    32'({ovr0, fe0, pe0}), 32'd0);
        chk("rst_busy",     32'(busy0), 32'd0);

        // reset in the middle of a looped-back frame
        resetn = 1'b1; loop = 1'b1;
        cyc(2);
        bus0.tx_data = 8'h00; bus0.tx_valid = 1'b1;
        cyc(3);
        bus0.tx_valid = 1'b0;
        cyc(100);
        chk("pre_rst_busy", 32'(busy0), 32'd1);
        chk("pre_rst_txd",  32'(txd0), 32'd0);
        chk("pre_rst_txl",  32'(txl0), 32'd2);
        resetn = 1'b0;
        #1;
        chk("mid_rst_txd",      32'(txd0), 32'd1);
        chk("mid_rst_tx_ready", 32'(bus0.tx_ready), 32'd1);
        chk("mid_rst_levels",   32'({txl0, rxl0}), 32'd0);
        chk("mid_rst_rx_valid", 32'(bus0.rx_valid), 32'd0);
        chk("mid_rst_busy",     32'(busy0), 32'd0);
        chk("mid_rst_flags",    32'({ovr0, fe0, pe0}), 32'd0);
        cyc(3);
        resetn = 1'b1;
        cyc(700);
        chk("post_rst_busy", 32'(busy0), 32'd0);
        chk("post_rst_rxl",  32'(rxl0), 32'd0);

        // TX framing of 0xA5
        loop = 1'b0;
        bus0.tx_data = 8'hA5; bus0.tx_valid = 1'b1;
        cyc(1);
        bus0.tx_valid = 1'b0;
        t = 0;
        while (!busy0 && t < 50) begin
            cyc(1);
            t++;
        end
        chk("tx_start_seen", 32'(busy0), 32'd1);
        fbits = {1'b1, 8'hA5, 1'b0};
        n = 0; edge_err = 0;
        while (busy0 && n < 1000) begin
            idx = (n / 64 > 9) ? 9 : n / 64;
            if (txd0 !== fbits[idx]) edge_err++;
            if (n % 64 == 32) chk($sformatf("tx_bit%0d", idx), 32'(txd0), 32'(fbits[idx]));
            cyc(1);
            n++;
        end
        chk("tx_edge_errs", 32'(edge_err), 32'd0);
        chk("tx_busy_len",  32'(n), 32'd640);
        chk("tx_idle_txd",  32'(txd0), 32'd1);

        // loopback of 20 bytes through a 16-deep TX FIFO
        loop = 1'b1;
        cyc(10);
        push_run(0, 20, pushed, stall_full, stall_bad, maxl);
        chk("lb_pushed",        32'(pushed), 32'd20);
        chk("lb_max_level",     32'(maxl), 32'd16);
        chk("lb_stall_at_full", 32'(stall_full > 0), 32'd1);
        chk("lb_stall_bad",     32'(stall_bad), 32'd0);
        for (int k = 0; k < 20; k++) pop0($sformatf("lb_byte%0d", k), 8'(k));
        chk("lb_flags",  32'({ovr0, fe0, pe0}), 32'd0);
        chk("lb_levels", 32'({txl0, rxl0}), 32'd0);

        // overrun: 17 bytes in, none popped
        push_run(8'h40, 17, pushed, stall_full, stall_bad, maxl);
        chk("ovr_pushed", 32'(pushed), 32'd17);
        t = 0;
        while ((busy0 || txl0 != 5'd0) && t < 15000) begin
            cyc(1);
            t++;
        end
        chk("ovr_drain", 32'(busy0), 32'd0);
        cyc(20);
        chk("ovr_rxl",  32'(rxl0), 32'd16);
        chk("ovr_flag", 32'(ovr0), 32'd1);
        chk("ovr_fe",   32'(fe0), 32'd0);
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        chk("ovr_clr", 32'(ovr0), 32'd0);
        for (int k = 0; k < 16; k++) pop0($sformatf("ovr_byte%0d", k), 8'(8'h40 + k));

        // frame error, then BREAK held while the line stays low
        loop = 1'b0; rxd_drv = 1'b1;
        cyc(50);
        send_frame(8'h55, 1'b0, 1'b0, 1'b0);
        cyc(10);
        chk("fe_flag", 32'(fe0), 32'd1);
        chk("fe_rxl",  32'(rxl0), 32'd0);
        chk("fe_pe",   32'(pe0), 32'd0);
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        cyc(800);
        chk("brk_hold_fe",  32'(fe0), 32'd0);
        chk("brk_hold_rxl", 32'(rxl0), 32'd0);
        rxd_drv = 1'b1;
        cyc(100);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
        cyc(10);
        chk("brk_exit_rxl", 32'(rxl0), 32'd1);
        pop0("brk_exit_byte", 8'h3C);
        chk("brk_exit_fe", 32'(fe0), 32'd0);

        // even parity instance: bad then good parity bit for 0x01
        sel1 = 1'b1; rxd_drv = 1'b1;
        cyc(50);
        send_frame(8'h01, 1'b1, 1'b0, 1'b1);
        cyc(10);
        chk("par_flag", 32'(pe1), 32'd1);
        chk("par_rxl",  32'(rxl1), 32'd0);
        chk("par_fe",   32'(fe1), 32'd0);
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        cyc(50);
        send_frame(8'h01, 1'b1, 1'b1, 1'b1);
        cyc(10);
        chk("par_ok_rxl",  32'(rxl1), 32'd1);
        chk("par_ok_data", 32'(bus1.rx_data), 32'h01);
        chk("par_ok_flag", 32'(pe1), 32'd0);
        sel1 = 1'b0;

        // 16 clk low pulse is shorter than half a bit
        rxd_drv = 1'b1;
        cyc(50);
        rxd_drv = 1'b0;
        cyc(16);
        rxd_drv = 1'b1;
        cyc(200);
        chk("glitch_rxl", 32'(rxl0), 32'd0);
        chk("glitch_fe",  32'(fe0), 32'd0);
        send_frame(8'h96, 1'b0, 1'b0, 1'b1);
        cyc(10);
        pop0("glitch_after", 8'h96);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
